// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle between the sequencer, the pipelined ALU and the consumer.
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       control;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             carry_out;
    logic             zero;
    logic             negative;
    logic             overflow;
    logic             illegal;

    modport master (
        output in_valid, a, b, control, out_ready,
        input  in_ready, out_valid, res, carry_out, zero, negative, overflow, illegal
    );

    modport slave (
        input  in_valid, a, b, control, out_ready,
        output in_ready, out_valid, res, carry_out, zero, negative, overflow, illegal
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: S1 captures operands, S2 computes and registers result plus flags.
// Valid/ready on both sides; at most two beats in flight.
module alu_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    alu_pipe_if.slave  bus
);
    localparam int unsigned WX = WIDTH + 1;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_ILL  = 3'b011;
    localparam logic [2:0] OP_ANDN = 3'b100;
    localparam logic [2:0] OP_ORN  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [2:0]       s1_op_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic             zero_q;
    logic             neg_q;
    logic             ovf_q;
    logic             ill_q;

    logic             s2_adv;
    logic             s1_adv;

    logic [WX-1:0]    sum_add;
    logic [WX-1:0]    sum_sub;
    logic             ovf_add;
    logic             ovf_sub;
    logic [WIDTH-1:0] res_d;
    logic             carry_d;
    logic             zero_d;
    logic             neg_d;
    logic             ovf_d;
    logic             ill_d;

    // Each stage advances when its downstream slot is free or being drained this cycle.
    assign s2_adv      = !out_valid_q || bus.out_ready;
    assign s1_adv      = !s1_valid_q || s2_adv;
    assign bus.in_ready = s1_adv;

    assign bus.out_valid = out_valid_q;
    assign bus.res       = res_q;
    assign bus.carry_out = carry_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = neg_q;
    assign bus.overflow  = ovf_q;
    assign bus.illegal   = ill_q;

    // Result and flag computation on the S1 operands; SLT uses sign^overflow of the subtraction.
    always_comb begin
        sum_add = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        sum_sub = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + WX'(1);
        ovf_add = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) && (sum_add[WIDTH-1] != s1_a_q[WIDTH-1]);
        ovf_sub = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) && (sum_sub[WIDTH-1] != s1_a_q[WIDTH-1]);

        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        ill_d   = 1'b0;
        unique case (s1_op_q)
            OP_AND:  res_d = s1_a_q & s1_b_q;
            OP_OR:   res_d = s1_a_q | s1_b_q;
            OP_ADD: begin
                res_d   = sum_add[WIDTH-1:0];
                carry_d = sum_add[WIDTH];
                ovf_d   = ovf_add;
            end
            OP_ILL:  ill_d = 1'b1;
            OP_ANDN: res_d = s1_a_q & ~s1_b_q;
            OP_ORN:  res_d = s1_a_q | ~s1_b_q;
            OP_SUB: begin
                res_d   = sum_sub[WIDTH-1:0];
                carry_d = sum_sub[WIDTH];
                ovf_d   = ovf_sub;
            end
            OP_SLT:  res_d = WIDTH'(sum_sub[WIDTH-1] ^ ovf_sub);
            default: res_d = '0;
        endcase
        zero_d = (res_d == '0);
        neg_d  = res_d[WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_a_q  <= bus.a;
                    s1_b_q  <= bus.b;
                    s1_op_q <= bus.control;
                end
            end
            // Result registers only change when a real beat moves in, so they hold while stalled.
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    res_q   <= res_d;
                    carry_q <= carry_d;
                    zero_q  <= zero_d;
                    neg_q   <= neg_d;
                    ovf_q   <= ovf_d;
                    ill_q   <= ill_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: three widths (8, 4, 16) share one stimulus stream; each has its own
// expected-result queue fed by an arithmetic reference model.
module tb_alu_pipe;
    localparam int NW = 3;

    localparam logic [2:0] ADD  = 3'b010;
    localparam logic [2:0] ILL  = 3'b011;
    localparam logic [2:0] ANDN = 3'b100;
    localparam logic [2:0] ORN  = 3'b101;
    localparam logic [2:0] SUB  = 3'b110;
    localparam logic [2:0] SLT  = 3'b111;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  fl;   // {carry, zero, negative, overflow, illegal}
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [2:0]  op;
    logic [31:0] a_v;
    logic [31:0] b_v;

    logic        ov [NW];
    logic        ir [NW];
    logic [31:0] rs [NW];
    logic [4:0]  fl [NW];

    exp_t        exp_q [NW][$];
    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    int unsigned n_pop = 0;
    logic        acc;
    logic        ov_s;

    always #5 clk = ~clk;

    function automatic int unsigned wid(int k);
        return (k == 0) ? 8 : (k == 1) ? 4 : 16;
    endfunction

    for (genvar gi = 0; gi < NW; gi++) begin : g_w
        localparam int unsigned W = (gi == 0) ? 8 : (gi == 1) ? 4 : 16;
        alu_pipe_if #(.WIDTH(W)) bus ();
        alu_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
        assign bus.in_valid  = in_valid;
        assign bus.a         = W'(a_v);
        assign bus.b         = W'(b_v);
        assign bus.control   = op;
        assign bus.out_ready = out_ready;
        assign ov[gi] = bus.out_valid;
        assign ir[gi] = bus.in_ready;
        assign rs[gi] = 32'(bus.res);
        assign fl[gi] = {bus.carry_out, bus.zero, bus.negative, bus.overflow, bus.illegal};
    end

    // Reference: unsigned/signed integer arithmetic on the masked operands.
    function automatic exp_t model(int unsigned w, logic [2:0] o, logic [31:0] a, logic [31:0] b);
        longint span;
        longint half;
        longint ua;
        longint ub;
        longint sa;
        longint sb;
        longint r;
        logic   c;
        logic   v;
        logic   il;
        exp_t   e;
        span = longint'(1) << w;
        half = span / 2;
        ua   = longint'(a) & (span - 1);
        ub   = longint'(b) & (span - 1);
        sa   = (ua >= half) ? ua - span : ua;
        sb   = (ub >= half) ? ub - span : ub;
        r    = 0;
        c    = 1'b0;
        v    = 1'b0;
        il   = 1'b0;
        case (o)
            3'b000: r = ua & ub;
            3'b001: r = ua | ub;
            3'b010: begin
                r = ua + ub;
                c = (r >= span);
                v = ((sa + sb) >= half) || ((sa + sb) < -half);
            end
            3'b011: il = 1'b1;
            3'b100: r = ua & (span - 1 - ub);
            3'b101: r = ua | (span - 1 - ub);
            3'b110: begin
                r = ua - ub;
                c = (ua >= ub);
                v = ((sa - sb) >= half) || ((sa - sb) < -half);
            end
            default: r = (sa < sb) ? 1 : 0;
        endcase
        r     = r & (span - 1);
        e.res = 32'(r);
        e.fl  = {c, (r == 0), (r >= half), v, il};
        return e;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    function automatic logic all_empty();
        return (exp_q[0].size() == 0) && (exp_q[1].size() == 0) && (exp_q[2].size() == 0);
    endfunction

    // One clock: sample at negedge, score outputs and handshakes, advance past posedge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        ov_s = ov[0];
        acc  = in_valid && ir[0];
        for (int k = 0; k < NW; k++) begin
            check($sformatf("w%0d_in_ready", wid(k)), 32'(ir[k]),
                  32'((exp_q[k].size() < 2) || out_ready));
            if (ov[k]) begin
                if (exp_q[k].size() == 0) begin
                    check($sformatf("w%0d_spurious", wid(k)), 32'(ov[k]), 32'(0));
                end else begin
                    e = exp_q[k][0];
                    check($sformatf("w%0d_res", wid(k)), rs[k], e.res);
                    check($sformatf("w%0d_flags", wid(k)), 32'(fl[k]), 32'(e.fl));
                    if (out_ready) begin
                        void'(exp_q[k].pop_front());
                        if (k == 0) n_pop++;
                    end
                end
            end
            if (in_valid && ir[k]) exp_q[k].push_back(model(wid(k), op, a_v, b_v));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(logic [2:0] o, logic [31:0] a, logic [31:0] b);
        op       = o;
        a_v      = a;
        b_v      = b;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (acc) break;
        end
        if (!acc) check("issue_timeout", 32'(acc), 32'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain(output int n);
        n = 0;
        while (n < 30 && !all_empty()) begin
            step();
            n++;
        end
        check("drain_done", 32'(all_empty()), 32'(1));
    endtask

    task automatic hold_chk(string tag, int k, logic [31:0] r, logic [4:0] f);
        check({tag, "_res"}, rs[k], r);
        check({tag, "_flags"}, 32'(fl[k]), 32'(f));
    endtask

    typedef struct {
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [4:0]  f;
    } vec_t;

    vec_t vecs [7] = '{
        '{SUB,  32'h80, 32'h01, 32'h7F, 5'b10010},
        '{SUB,  32'h00, 32'h01, 32'hFF, 5'b00100},
        '{SLT,  32'h80, 32'h7F, 32'h01, 5'b00000},
        '{SLT,  32'h7F, 32'h80, 32'h00, 5'b01000},
        '{ANDN, 32'hCC, 32'hAA, 32'h44, 5'b00000},
        '{ORN,  32'hCC, 32'hAA, 32'hDD, 5'b00100},
        '{ILL,  32'h5A, 32'h33, 32'h00, 5'b01001}
    };

    initial begin
        int          n;
        int unsigned c0;
        int unsigned p0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = '0;
        a_v       = '0;
        b_v       = '0;
        acc       = 1'b0;
        ov_s      = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        for (int k = 0; k < NW; k++) begin
            check($sformatf("w%0d_rst_valid", wid(k)), 32'(ov[k]), 32'(0));
            check($sformatf("w%0d_rst_res", wid(k)), rs[k], 32'(0));
            check($sformatf("w%0d_rst_flags", wid(k)), 32'(fl[k]), 32'(0));
            check($sformatf("w%0d_rst_ready", wid(k)), 32'(ir[k]), 32'(1));
        end

        // All-ones + 1 wraps to zero with carry at every width; check fill latency.
        issue(ADD, 32'hFFFF_FFFF, 32'h1);
        step();
        check("lat_cycle1", 32'(ov_s), 32'(0));
        step();
        check("lat_cycle2", 32'(ov_s), 32'(1));
        drain(n);
        for (int k = 0; k < NW; k++) hold_chk($sformatf("w%0d_add_wrap", wid(k)), k, 32'h0, 5'b11000);

        foreach (vecs[i]) begin
            issue(vecs[i].o, vecs[i].a, vecs[i].b);
            drain(n);
            hold_chk($sformatf("w8_vec%0d", i), 0, vecs[i].r, vecs[i].f);
        end

        issue(SLT, 32'h8, 32'h7);
        drain(n);
        hold_chk("w4_slt_min", 1, 32'h1, 5'b00000);
        issue(SLT, 32'h8000, 32'h7FFF);
        drain(n);
        hold_chk("w16_slt_min", 2, 32'h1, 5'b00000);

        // Backpressure: two beats fill the pipe, the third waits until the consumer drains.
        out_ready = 1'b0;
        issue(ADD, 32'h1, 32'h1);
        issue(ADD, 32'h2, 32'h2);
        op       = ADD;
        a_v      = 32'h3;
        b_v      = 32'h3;
        in_valid = 1'b1;
        repeat (3) step();
        check("bp_not_taken", 32'(acc), 32'(0));
        check("bp_in_ready", 32'(ir[0]), 32'(0));
        check("bp_res_held", rs[0], 32'h2);
        p0        = n_pop;
        out_ready = 1'b1;
        step();
        check("bp_take_same_cycle", 32'(acc), 32'(1));
        in_valid = 1'b0;
        step();
        step();
        check("bp_pops_consecutive", n_pop - p0, 32'(3));
        check("bp_last_res", rs[0], 32'h6);
        drain(n);

        // Full-rate stream.
        c0 = cyc;
        for (int i = 0; i < 16; i++) issue(3'($urandom), $urandom, $urandom);
        check("stream_rate", cyc - c0, 32'(16));
        drain(n);
        check("stream_drain", 32'(n), 32'(2));

        // Reset with two beats in flight.
        out_ready = 1'b0;
        issue(ADD, 32'h11, 32'h22);
        issue(SUB, 32'h33, 32'h44);
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < NW; k++) begin
            check($sformatf("w%0d_midrst_valid", wid(k)), 32'(ov[k]), 32'(0));
            check($sformatf("w%0d_midrst_res", wid(k)), rs[k], 32'(0));
            exp_q[k].delete();
        end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(ir[0]), 32'(1));
        out_ready = 1'b1;
        repeat (5) step();
        issue(ADD, 32'h5, 32'h7);
        drain(n);
        hold_chk("w8_post_rst", 0, 32'hC, 5'b00000);

        // Random traffic with random backpressure; the source holds a beat until taken.
        for (int i = 0; i < 300; i++) begin
            if (!in_valid || acc) begin
                in_valid = 1'($urandom_range(0, 1));
                op       = 3'($urandom);
                a_v      = $urandom;
                b_v      = $urandom;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1);
    end
endmodule
